// File: rtl/io_timer.sv
// Memory-mapped 32-bit timer with compare match, auto-reload and a level interrupt.
// Optional 16-bit prescaler is compiled in when IO_TIMER_PRESCALE_EN is defined.
module io_timer #(
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Read,
  input  logic        Write,
  input  logic [2:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ack,
  output logic        Interrupt,
  output logic [0:0]  fsm_state
);

  // Bus handshake: the CPU holds Read/Write high until it sees Ack; one
  // transaction is accepted on IDLE->ACK and the FSM waits in ACK until the
  // request is released, so a held request is never performed twice.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  localparam logic [2:0] ADDR_COUNT    = 3'd0;
  localparam logic [2:0] ADDR_COMPARE  = 3'd1;
  localparam logic [2:0] ADDR_CONTROL  = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [31:0] count;
  logic [31:0] compare;
  logic [2:0]  ctrl;
  logic        match;
  logic [31:0] rdata;
  logic        start;
  logic        wr;
  logic        en;
  logic        tick;
  logic        hit;

  assign fsm_state = state;
  assign start     = (state == IDLE) && (Read || Write);
  assign wr        = start && Write;
  assign en        = ctrl[0];
  assign hit       = (count == compare);
  assign Interrupt = match && ctrl[2];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Read || Write) state_next = ACK;
      ACK:     if (!(Read || Write)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef IO_TIMER_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] div_count;

  assign tick = (div_count == prescale);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prescale  <= 16'd0;
      div_count <= 16'd0;
    end else if (wr && (Address == ADDR_PRESCALE)) begin
      prescale  <= DataIn[15:0];
      div_count <= 16'd0;
    end else if (en) begin
      div_count <= tick ? 16'd0 : div_count + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    rdata = 32'd0;
    case (Address)
      ADDR_COUNT:    rdata = count;
      ADDR_COMPARE:  rdata = compare;
      ADDR_CONTROL:  rdata = {29'd0, ctrl};
      ADDR_STATUS:   rdata = {31'd0, match};
`ifdef IO_TIMER_PRESCALE_EN
      ADDR_PRESCALE: rdata = {16'd0, prescale};
`endif
      default:       rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      Ack     <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      state <= state_next;
      Ack   <= (state_next == ACK);
      if (start && Read) DataOut <= Write ? 32'd0 : rdata;
    end
  end

  // A CPU write to COUNT takes priority over the tick; a match set wins over a STATUS clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count   <= 32'd0;
      compare <= RESET_COMPARE;
      ctrl    <= 3'd0;
      match   <= 1'b0;
    end else begin
      if (wr && (Address == ADDR_COUNT)) count <= DataIn;
      else if (en && tick) count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;

      if (wr && (Address == ADDR_COMPARE)) compare <= DataIn;
      if (wr && (Address == ADDR_CONTROL)) ctrl <= DataIn[2:0];

      if (en && tick && hit) match <= 1'b1;
      else if (wr && (Address == ADDR_STATUS) && DataIn[0]) match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_timer.sv
// Directed testbench for io_timer: handshake, register map, match/reload,
// wrap, write/tick collisions, reset during a transaction and the prescaler.
module tb_io_timer;

  logic        clock;
  logic        reset_n;
  logic        Read;
  logic        Write;
  logic [2:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ack;
  logic        Interrupt;
  logic [0:0]  fsm_state;

  int tests_run;
  int tests_failed;

  io_timer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .Read      (Read),
    .Write     (Write),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .Ack       (Ack),
    .Interrupt (Interrupt),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: called at a negedge, return at a negedge
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    int n;
    Address = a;
    DataIn  = d;
    Write   = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!Ack && n < 8);
    tests_run++;
    if (Ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_ack addr=%0d: Ack=%b, required 1", a, Ack);
    end
    Write = 1'b0;
    @(negedge clock);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    int n;
    Address = a;
    Read    = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!Ack && n < 8);
    tests_run++;
    if (Ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_ack addr=%0d: Ack=%b, required 1", a, Ack);
    end
    d    = DataOut;
    Read = 1'b0;
    @(negedge clock);
  endtask

  // Assert a write for one sampling edge only; returns at the negedge just after it lands.
  task automatic bus_start_write(input logic [2:0] a, input logic [31:0] d);
    Address = a;
    DataIn  = d;
    Write   = 1'b1;
    @(negedge clock);
    tests_run++;
    if (Ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_write_ack addr=%0d: Ack=%b, required 1", a, Ack);
    end
    Write = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    Address = 3'd0;
    DataIn  = 32'd0;
    repeat (3) @(negedge clock);
    tests_run++;
    if (Ack !== 1'b0 || DataOut !== 32'd0 || Interrupt !== 1'b0 || fsm_state !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: Ack=%b DataOut=%h Interrupt=%b state=%b, required 0/0/0/0",
               Ack, DataOut, Interrupt, fsm_state);
    end
  endtask

  task automatic test_handshake();
    reset_n = 1'b1;
    Read    = 1'b1;
    Address = 3'd1;
    tests_run++;
    if (Ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_cycle0: Ack=%b, required 0", Ack);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      tests_run++;
      if (Ack !== 1'b1) begin
        tests_failed++;
        $display("FAIL hs_ack_cycle%0d: Ack=%b, required 1", i, Ack);
      end
    end
    tests_run++;
    if (DataOut !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL hs_dataout: DataOut=%h, required ffffffff", DataOut);
    end
    Read = 1'b0;
    @(negedge clock);
    tests_run++;
    if (Ack !== 1'b0 || DataOut !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL hs_release: Ack=%b DataOut=%h, required 0/ffffffff", Ack, DataOut);
    end
  endtask

  task automatic test_registers();
    logic [31:0] d;
    bus_read(3'd0, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL reg_count_reset: got %h, required 0", d);
    end
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL reg_status_reset: got %h, required 0", d);
    end
    bus_write(3'd2, 32'hFFFF_FFF2);
    bus_read(3'd2, d);
    tests_run++;
    if (d !== 32'd2) begin
      tests_failed++;
      $display("FAIL reg_control_mask: got %h, required 2", d);
    end
    bus_write(3'd6, 32'h1234_5678);
    tests_run++;
    if (DataOut !== 32'd2) begin
      tests_failed++;
      $display("FAIL dataout_hold_on_write: DataOut=%h, required 2", DataOut);
    end
    bus_read(3'd6, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL reg_addr6: got %h, required 0", d);
    end
    bus_read(3'd5, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL reg_addr5: got %h, required 0", d);
    end
    bus_write(3'd2, 32'd0);
  endtask

  task automatic test_read_write_both();
    logic [31:0] d;
    bus_read(3'd1, d);
    Address = 3'd1;
    DataIn  = 32'h0000_ABCD;
    Read    = 1'b1;
    Write   = 1'b1;
    @(negedge clock);
    tests_run++;
    if (Ack !== 1'b1 || DataOut !== 32'd0) begin
      tests_failed++;
      $display("FAIL rw_both_dataout: Ack=%b DataOut=%h, required 1/0", Ack, DataOut);
    end
    Read  = 1'b0;
    Write = 1'b0;
    @(negedge clock);
    bus_read(3'd1, d);
    tests_run++;
    if (d !== 32'h0000_ABCD) begin
      tests_failed++;
      $display("FAIL rw_both_write: COMPARE=%h, required 0000abcd", d);
    end
  endtask

  task automatic test_match_reload();
    logic [31:0] exp_count [7] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
    bus_write(3'd0, 32'd0);
    bus_write(3'd1, 32'd5);
    bus_write(3'd3, 32'd1);
    bus_start_write(3'd2, 32'd7);
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (dut.count !== exp_count[i] || Interrupt !== (i == 6)) begin
        tests_failed++;
        $display("FAIL match_seq[%0d]: COUNT=%h Interrupt=%b, required %h/%b",
                 i, dut.count, Interrupt, exp_count[i], (i == 6));
      end
      if (i < 6) @(negedge clock);
    end
    bus_write(3'd3, 32'd1);
    tests_run++;
    if (Interrupt !== 1'b0) begin
      tests_failed++;
      $display("FAIL match_clear: Interrupt=%b, required 0", Interrupt);
    end
    bus_write(3'd2, 32'd0);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [31:0] exp_count [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
    bus_write(3'd1, 32'd10);
    bus_write(3'd0, 32'hFFFF_FFFE);
    bus_write(3'd3, 32'd1);
    bus_start_write(3'd2, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (dut.count !== exp_count[i]) begin
        tests_failed++;
        $display("FAIL wrap_seq[%0d]: COUNT=%h, required %h", i, dut.count, exp_count[i]);
      end
      if (i < 3) @(negedge clock);
    end
    bus_write(3'd2, 32'd0);
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL wrap_no_match: STATUS=%h, required 0", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    int n;
    bus_write(3'd1, 32'h0000_1000);
    bus_start_write(3'd2, 32'd1);
    repeat (2) @(negedge clock);
    bus_start_write(3'd0, 32'd100);
    tests_run++;
    if (dut.count !== 32'd100) begin
      tests_failed++;
      $display("FAIL collide_count_write: COUNT=%0d, required 100", dut.count);
    end
    @(negedge clock);
    tests_run++;
    if (dut.count !== 32'd101) begin
      tests_failed++;
      $display("FAIL collide_count_next: COUNT=%0d, required 101", dut.count);
    end
    bus_write(3'd2, 32'd0);

    bus_write(3'd1, 32'd50);
    bus_write(3'd0, 32'd45);
    bus_write(3'd3, 32'd1);
    bus_start_write(3'd2, 32'd1);
    n = 0;
    while (dut.count !== 32'd50 && n < 20) begin
      @(negedge clock);
      n++;
    end
    tests_run++;
    if (dut.count !== 32'd50) begin
      tests_failed++;
      $display("FAIL collide_reach_compare: COUNT=%0d, required 50", dut.count);
    end
    Address = 3'd3;
    DataIn  = 32'd1;
    Write   = 1'b1;
    @(negedge clock);
    Write = 1'b0;
    @(negedge clock);
    bus_write(3'd2, 32'd0);
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'd1) begin
      tests_failed++;
      $display("FAIL collide_set_wins: STATUS=%h, required 1", d);
    end
    bus_write(3'd3, 32'd0);
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'd1) begin
      tests_failed++;
      $display("FAIL status_write0_noop: STATUS=%h, required 1", d);
    end
    bus_write(3'd3, 32'd1);
    bus_read(3'd3, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL status_write1_clear: STATUS=%h, required 0", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(3'd1, 32'd77);
    bus_write(3'd2, 32'd4);
    Address = 3'd0;
    DataIn  = 32'h0000_1234;
    Write   = 1'b1;
    @(negedge clock);
    tests_run++;
    if (Ack !== 1'b1 || dut.count !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL rmid_first_write: Ack=%b COUNT=%h, required 1/00001234", Ack, dut.count);
    end
    reset_n = 1'b0;
    @(negedge clock);
    tests_run++;
    if (Ack !== 1'b0 || DataOut !== 32'd0 || dut.count !== 32'd0 ||
        dut.compare !== 32'hFFFF_FFFF || dut.ctrl !== 3'd0 || dut.match !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_reset_values: Ack=%b DataOut=%h COUNT=%h COMPARE=%h CTRL=%b MATCH=%b, required 0/0/0/ffffffff/000/0",
               Ack, DataOut, dut.count, dut.compare, dut.ctrl, dut.match);
    end
    reset_n = 1'b1;
    @(negedge clock);
    tests_run++;
    if (Ack !== 1'b1 || dut.count !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL rmid_new_txn: Ack=%b COUNT=%h, required 1/00001234", Ack, dut.count);
    end
    Write = 1'b0;
    @(negedge clock);
    tests_run++;
    if (Ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_release: Ack=%b, required 0", Ack);
    end
    bus_read(3'd1, d);
    tests_run++;
    if (d !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL rmid_compare: COMPARE=%h, required ffffffff", d);
    end
    bus_read(3'd0, d);
    tests_run++;
    if (d !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL rmid_count_once: COUNT=%h, required 00001234", d);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
`ifdef IO_TIMER_PRESCALE_EN
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'd0);
    bus_write(3'd4, 32'hFFFF_0003);
    bus_read(3'd4, d);
    tests_run++;
    if (d !== 32'd3) begin
      tests_failed++;
      $display("FAIL prescale_readback: got %h, required 3", d);
    end
    bus_start_write(3'd2, 32'd1);
    for (int k = 0; k < 9; k++) begin
      tests_run++;
      if (dut.count !== 32'(k / 4)) begin
        tests_failed++;
        $display("FAIL prescale_seq[%0d]: COUNT=%0d, required %0d", k, dut.count, k / 4);
      end
      if (k < 8) @(negedge clock);
    end
    bus_write(3'd2, 32'd0);
`else
    bus_write(3'd4, 32'h1234_5678);
    bus_read(3'd4, d);
    tests_run++;
    if (d !== 32'd0) begin
      tests_failed++;
      $display("FAIL prescale_absent: got %h, required 0", d);
    end
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_handshake();
    test_registers();
    test_read_write_both();
    test_match_reload();
    test_wrap();
    test_collision();
    test_reset_mid();
    test_prescale();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
